// File: rtl/vending_pkg.sv
// Shared types and constants for the vending transaction controller.
// Holds the FSM state encoding, keypad code map and coin values.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  localparam int unsigned KEY_W  = 4;
  localparam int unsigned ITEM_W = 3;

  localparam logic [KEY_W-1:0] KEY_COIN1  = 4'hA;
  localparam logic [KEY_W-1:0] KEY_COIN5  = 4'hB;
  localparam logic [KEY_W-1:0] KEY_COIN10 = 4'hC;
  localparam logic [KEY_W-1:0] KEY_CANCEL = 4'hE;

  localparam int unsigned COIN1_VAL  = 1;
  localparam int unsigned COIN5_VAL  = 5;
  localparam int unsigned COIN10_VAL = 10;

endpackage

// File: rtl/vending_controller_dispense_timer.sv
// Loadable down-counter that times the dispense pulse.
// Ports: clk, reset (sync, active-high), i_load (load CYCLES),
//        o_done_c (combinational: counter is on its last count).
module dispense_timer #(
  parameter int unsigned CYCLES = 4,
  localparam int unsigned CNT_W = $clog2(CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  output logic o_done_c
);

  logic [CNT_W-1:0] r_count;

  // Counts down to zero and rests there until the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(CYCLES);
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_done_c = (r_count == CNT_W'(1));

endmodule

// File: rtl/vending_controller.sv
// Vending transaction controller: accumulates coin credit, prices item
// selections, times the dispense pulse and returns change.
// Ports: clk, reset (sync, active-high), key_valid/key_value (keypad strobe),
//        credit, dispense, item, change_valid, change_amount, deny, busy
//        (all registered).
module vending_controller
  import vending_pkg::*;
#(
  parameter int unsigned NUM_ITEMS       = 4,
  parameter int unsigned PRICE_W         = 8,
  parameter int unsigned MAX_CREDIT      = 250,
  parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICES = {8'd40, 8'd30, 8'd25, 8'd15},
  parameter int unsigned DISPENSE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [KEY_W-1:0]   key_value,
  output logic [PRICE_W-1:0] credit,
  output logic               dispense,
  output logic [ITEM_W-1:0]  item,
  output logic               change_valid,
  output logic [PRICE_W-1:0] change_amount,
  output logic               deny,
  output logic               busy
);

  localparam int unsigned SUM_W = PRICE_W + 1;

  state_t             r_state, w_state_nxt;
  logic [PRICE_W-1:0] r_credit, w_credit_nxt;
  logic [ITEM_W-1:0]  r_item, w_item_nxt;
  logic [PRICE_W-1:0] r_change_amount, w_change_amount_nxt;
  logic               r_change_valid, w_change_valid_nxt;
  logic               r_deny, w_deny_nxt;
  logic               r_dispense, w_dispense_nxt;
  logic               r_busy, w_busy_nxt;

  logic               w_is_coin, w_is_select, w_is_cancel;
  logic [PRICE_W-1:0] w_coin_val, w_price;
  logic [ITEM_W-1:0]  w_sel_idx;
  logic [SUM_W-1:0]   w_sum;
  logic               w_coin_ok, w_price_ok;
  logic               w_load_timer, w_timer_done;

  // Keypad decode.
  always_comb begin
    w_is_coin   = 1'b0;
    w_coin_val  = '0;
    w_is_cancel = 1'b0;
    if (key_valid) begin
      case (key_value)
        KEY_COIN1:  begin w_is_coin = 1'b1; w_coin_val = PRICE_W'(COIN1_VAL);  end
        KEY_COIN5:  begin w_is_coin = 1'b1; w_coin_val = PRICE_W'(COIN5_VAL);  end
        KEY_COIN10: begin w_is_coin = 1'b1; w_coin_val = PRICE_W'(COIN10_VAL); end
        KEY_CANCEL: w_is_cancel = 1'b1;
        default:    ;
      endcase
    end
  end

  assign w_is_select = key_valid && (32'(key_value) < NUM_ITEMS);
  assign w_sel_idx   = key_value[ITEM_W-1:0];

  // Price table mux; item i sits at bits [i*PRICE_W +: PRICE_W].
  always_comb begin
    w_price = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (w_sel_idx == ITEM_W'(i)) begin
        w_price = PRICES[i*PRICE_W +: PRICE_W];
      end
    end
  end

  // Sum carries one extra bit so an overflowing coin is rejected, not wrapped.
  assign w_sum      = SUM_W'(r_credit) + SUM_W'(w_coin_val);
  assign w_coin_ok  = (w_sum <= SUM_W'(MAX_CREDIT));
  assign w_price_ok = (r_credit >= w_price);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt         = r_state;
    w_credit_nxt        = r_credit;
    w_item_nxt          = r_item;
    w_change_amount_nxt = r_change_amount;
    w_change_valid_nxt  = 1'b0;
    w_deny_nxt          = 1'b0;
    w_load_timer        = 1'b0;

    case (r_state)
      ST_IDLE, ST_CREDIT: begin
        if (w_is_coin) begin
          if (w_coin_ok) begin
            w_credit_nxt = w_sum[PRICE_W-1:0];
            w_state_nxt  = ST_CREDIT;
          end else begin
            w_deny_nxt = 1'b1;
          end
        end else if (w_is_select) begin
          // In IDLE credit is zero, so only a free item passes this check.
          if (w_price_ok) begin
            w_credit_nxt = r_credit - w_price;
            w_item_nxt   = w_sel_idx;
            w_load_timer = 1'b1;
            w_state_nxt  = ST_DISPENSE;
          end else begin
            w_deny_nxt = 1'b1;
          end
        end else if (w_is_cancel && (r_state == ST_CREDIT)) begin
          w_change_amount_nxt = r_credit;
          w_change_valid_nxt  = 1'b1;
          w_credit_nxt        = '0;
          w_state_nxt         = ST_CHANGE;
        end
      end

      ST_DISPENSE: begin
        if (w_timer_done) begin
          if (r_credit != '0) begin
            w_change_amount_nxt = r_credit;
            w_change_valid_nxt  = 1'b1;
            w_credit_nxt        = '0;
            w_state_nxt         = ST_CHANGE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      ST_CHANGE: w_state_nxt = ST_IDLE;

      default: w_state_nxt = ST_IDLE;
    endcase

    w_dispense_nxt = (w_state_nxt == ST_DISPENSE);
    w_busy_nxt     = (w_state_nxt == ST_DISPENSE) || (w_state_nxt == ST_CHANGE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_credit        <= '0;
      r_item          <= '0;
      r_change_amount <= '0;
      r_change_valid  <= 1'b0;
      r_deny          <= 1'b0;
      r_dispense      <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_credit        <= w_credit_nxt;
      r_item          <= w_item_nxt;
      r_change_amount <= w_change_amount_nxt;
      r_change_valid  <= w_change_valid_nxt;
      r_deny          <= w_deny_nxt;
      r_dispense      <= w_dispense_nxt;
      r_busy          <= w_busy_nxt;
    end
  end

  dispense_timer #(
    .CYCLES (DISPENSE_CYCLES)
  ) u_dispense_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load_timer),
    .o_done_c (w_timer_done)
  );

  assign credit        = r_credit;
  assign dispense      = r_dispense;
  assign item          = r_item;
  assign change_valid  = r_change_valid;
  assign change_amount = r_change_amount;
  assign deny          = r_deny;
  assign busy          = r_busy;

endmodule
